// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the program counter through a
// registered-output instruction memory and issues one instruction at a time.
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH  = 6,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0,
    parameter logic [2:0]            HALT_OPCODE = 3'b111
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] address,
    input  logic [2:0]            opcode_in,
    input  logic [DATA_WIDTH-1:0] data_a_in,
    input  logic [DATA_WIDTH-1:0] data_b_in,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [2:0]            opcode,
    output logic [DATA_WIDTH-1:0] operand_a,
    output logic [DATA_WIDTH-1:0] operand_b,
    output logic                  halted,
    output logic                  pc_wrap,
    output logic [7:0]            instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_HALTED
    } state_e;

    // Each instruction is three bytes: opcode, operand A, operand B.
    localparam logic [ADDR_WIDTH:0] PC_STEP = (ADDR_WIDTH + 1)'(3);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    valid_q, valid_d;
    logic [2:0]              opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0]   opa_q, opa_d;
    logic [DATA_WIDTH-1:0]   opb_q, opb_d;
    logic                    halted_q, halted_d;
    logic                    wrap_q, wrap_d;
    logic [7:0]              count_q, count_d;

    // Carry out of this sum flags a pc wrap past the top of memory.
    logic [ADDR_WIDTH:0]     pc_sum;
    logic [7:0]              count_inc;
    logic                    accept;

    assign pc_sum    = {1'b0, pc_q} + PC_STEP;
    assign count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    assign accept    = valid_q && instr_ready;

    // Next-state and next-output selection for the fetch FSM.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        opcode_d = opcode_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        halted_d = halted_q;
        wrap_d   = 1'b0;
        count_d  = count_q;
        unique case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Memory read latency: address has been presented this cycle.
                state_d = S_LOAD;
            end
            S_LOAD: begin
                opcode_d = opcode_in;
                opa_d    = data_a_in;
                opb_d    = data_b_in;
                valid_d  = 1'b1;
                state_d  = S_ISSUE;
            end
            S_ISSUE: begin
                if (accept) begin
                    valid_d = 1'b0;
                    count_d = count_inc;
                    if (opcode_q == HALT_OPCODE) begin
                        halted_d = 1'b1;
                        state_d  = S_HALTED;
                    end else begin
                        pc_d    = pc_sum[ADDR_WIDTH-1:0];
                        wrap_d  = pc_sum[ADDR_WIDTH];
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALTED: begin
                valid_d = 1'b0;
                if (start) begin
                    pc_d     = START_ADDR;
                    count_d  = 8'd0;
                    halted_d = 1'b0;
                    state_d  = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared at once by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= START_ADDR;
            valid_q  <= 1'b0;
            opcode_q <= 3'd0;
            opa_q    <= '0;
            opb_q    <= '0;
            halted_q <= 1'b0;
            wrap_q   <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            halted_q <= halted_d;
            wrap_q   <= wrap_d;
            count_q  <= count_d;
        end
    end

    assign address     = pc_q;
    assign instr_valid = valid_q;
    assign opcode      = opcode_q;
    assign operand_a   = opa_q;
    assign operand_b   = opb_q;
    assign halted      = halted_q;
    assign pc_wrap     = wrap_q;
    assign instr_count = count_q;

endmodule
